// File: rtl/pong_ball_engine.sv
// Ball-motion engine for the Pong datapath: position, direction, slope and
// speed-up register file driven by the game FSM state and collision inputs.
module pong_ball_engine #(
  parameter int unsigned SCR_W       = 640,
  parameter int unsigned SCR_H       = 480,
  parameter int unsigned BALL_SZ     = 16,
  parameter int unsigned CW          = 19,
  parameter int unsigned PERIOD_INIT = (2 ** CW) - 1,
  parameter int unsigned PERIOD_MIN  = 2 ** (CW - 1),
  parameter int unsigned PERIOD_STEP = 12500,
  parameter int unsigned MAX_DY      = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    state,
  input  logic          serve_dir,
  input  logic          hit_left,
  input  logic          hit_right,
  input  logic          hit_top,
  input  logic          hit_bottom,
  input  logic [1:0]    hit_zone,
  output logic [9:0]    ball_x,
  output logic [9:0]    ball_y,
  output logic [1:0]    ball_status,
  output logic          score_pulse,
  output logic [CW-1:0] period
);

  localparam logic [9:0]    LP_OX    = 10'((SCR_W - BALL_SZ) / 2);
  localparam logic [9:0]    LP_OY    = 10'((SCR_H - BALL_SZ) / 2);
  localparam logic [9:0]    LP_XMAX  = 10'(SCR_W - BALL_SZ);
  localparam logic [9:0]    LP_YMAX  = 10'(SCR_H - BALL_SZ);
  localparam logic [CW-1:0] LP_PINIT = CW'(PERIOD_INIT);
  localparam logic [CW-1:0] LP_PMIN  = CW'(PERIOD_MIN);
  localparam logic [CW-1:0] LP_PSTEP = CW'(PERIOD_STEP);
  localparam logic [CW:0]   LP_FLOOR = (CW + 1)'(PERIOD_MIN + PERIOD_STEP);

  typedef enum logic [1:0] {
    GS_START = 2'b00,
    GS_SERVE = 2'b01,
    GS_PLAY  = 2'b10,
    GS_DONE  = 2'b11
  } game_t;

  typedef enum logic [1:0] {
    BS_PLAYING = 2'b00,
    BS_P1      = 2'b01,
    BS_P2      = 2'b10
  } ball_st_t;

  logic [9:0]    r_x, r_y;
  ball_st_t      r_status;
  logic          r_pulse;
  logic [CW-1:0] r_period;
  logic [CW-1:0] r_cnt;
  logic          r_dirx, r_diry;
  logic [1:0]    r_dy;

  game_t         w_game;
  logic          w_tick;
  logic [CW-1:0] w_period_dec;
  logic [1:0]    w_dy_hit;
  logic [9:0]    w_x_next, w_y_next;

  always_comb begin
    w_game = game_t'(state);
    // >= rather than == so a period shortened below the running count still ticks
    w_tick = (r_cnt >= r_period);
    w_period_dec = ({1'b0, r_period} >= LP_FLOOR) ? r_period - LP_PSTEP : LP_PMIN;
    w_dy_hit = (32'(hit_zone) > MAX_DY) ? 2'(MAX_DY) : hit_zone;
    w_x_next = r_dirx ? r_x - 10'd1 : r_x + 10'd1;
    if (r_diry)
      w_y_next = (r_y < 10'(r_dy)) ? '0 : r_y - 10'(r_dy);
    else
      w_y_next = (({1'b0, r_y} + 11'(r_dy)) > {1'b0, LP_YMAX}) ? LP_YMAX : r_y + 10'(r_dy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x      <= LP_OX;
      r_y      <= LP_OY;
      r_status <= BS_PLAYING;
      r_pulse  <= 1'b0;
      r_period <= LP_PINIT;
      r_cnt    <= '0;
      r_dirx   <= 1'b0;
      r_diry   <= 1'b0;
      r_dy     <= 2'd1;
    end else begin
      case (w_game)
        GS_START, GS_DONE: begin
          r_x      <= LP_OX;
          r_y      <= LP_OY;
          r_status <= BS_PLAYING;
          r_pulse  <= 1'b0;
          r_cnt    <= '0;
          r_dirx   <= 1'b0;
          r_diry   <= 1'b0;
          r_dy     <= 2'd1;
          if (w_game == GS_START) r_period <= LP_PINIT;
        end
        GS_SERVE: begin
          r_x      <= LP_OX;
          r_y      <= LP_OY;
          r_status <= BS_PLAYING;
          r_pulse  <= 1'b0;
          r_cnt    <= '0;
          r_period <= LP_PINIT;
          r_dy     <= 2'd1;
          r_dirx   <= serve_dir;
          r_diry   <= ~r_diry;
        end
        GS_PLAY: begin
          r_pulse <= 1'b0;
          if (r_status == BS_PLAYING) begin
            r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
            if (hit_left && hit_right) begin
              r_dirx <= ~r_dirx;
            end else if (hit_left || hit_right) begin
              r_dirx   <= hit_right;
              r_period <= w_period_dec;
              r_dy     <= w_dy_hit;
            end
            if (hit_top && hit_bottom) r_diry <= ~r_diry;
            else if (hit_bottom)       r_diry <= 1'b1;
            else if (hit_top)          r_diry <= 1'b0;
            // The move uses the pre-hit direction/slope; a point freezes the ball in place
            if (w_tick) begin
              if (r_x == '0) begin
                r_status <= BS_P2;
                r_pulse  <= 1'b1;
              end else if (r_x == LP_XMAX) begin
                r_status <= BS_P1;
                r_pulse  <= 1'b1;
              end else begin
                r_x <= w_x_next;
                r_y <= w_y_next;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ball_x      = r_x;
  assign ball_y      = r_y;
  assign ball_status = r_status;
  assign score_pulse = r_pulse;
  assign period      = r_period;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine: a fast instance for motion/scoring and
// a slow instance for the period speed-up sequence, sharing one input set.
module tb_pong_ball_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  state;
  logic        serve_dir, hl, hr, ht, hb;
  logic [1:0]  hit_zone;

  logic [9:0]  a_x, a_y, b_x, b_y;
  logic [1:0]  a_st, b_st;
  logic        a_pulse, b_pulse;
  logic [18:0] a_period, b_period;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pong_ball_engine #(
    .CW(19), .PERIOD_INIT(3), .PERIOD_MIN(1), .PERIOD_STEP(1)
  ) u_fast (
    .clk(clk), .rst(rst), .state(state), .serve_dir(serve_dir),
    .hit_left(hl), .hit_right(hr), .hit_top(ht), .hit_bottom(hb),
    .hit_zone(hit_zone), .ball_x(a_x), .ball_y(a_y),
    .ball_status(a_st), .score_pulse(a_pulse), .period(a_period)
  );

  pong_ball_engine #(
    .CW(19), .PERIOD_INIT(40000), .PERIOD_MIN(20000), .PERIOD_STEP(12500)
  ) u_slow (
    .clk(clk), .rst(rst), .state(state), .serve_dir(serve_dir),
    .hit_left(hl), .hit_right(hr), .hit_top(ht), .hit_bottom(hb),
    .hit_zone(hit_zone), .ball_x(b_x), .ball_y(b_y),
    .ball_status(b_st), .score_pulse(b_pulse), .period(b_period)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // START for one clock, SERVE for one clock, then PLAY is applied (not yet clocked)
  task automatic start_serve_play(input logic dir);
    state = 2'b00;
    tick();
    serve_dir = dir;
    state = 2'b01;
    tick();
    state = 2'b10;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    state = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (a_x !== 10'd312) begin failures++; $display("FAIL reset_x got %0d want 312", a_x); end
    checks++; if (a_y !== 10'd232) begin failures++; $display("FAIL reset_y got %0d want 232", a_y); end
    checks++; if (a_st !== 2'b00) begin failures++; $display("FAIL reset_status got %b want 00", a_st); end
    checks++; if (a_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse got %b want 0", a_pulse); end
    checks++; if (a_period !== 19'd3) begin failures++; $display("FAIL reset_period_fast got %0d want 3", a_period); end
    checks++; if (b_period !== 19'd40000) begin failures++; $display("FAIL reset_period_slow got %0d want 40000", b_period); end
  endtask

  task automatic test_serve_move();
    start_serve_play(1'b0);
    tick(); tick(); tick();
    checks++; if (a_x !== 10'd312) begin failures++; $display("FAIL move_wait_x got %0d want 312", a_x); end
    tick();
    checks++; if (a_x !== 10'd313) begin failures++; $display("FAIL move_first_x got %0d want 313", a_x); end
    checks++; if (a_y !== 10'd231) begin failures++; $display("FAIL move_first_y got %0d want 231", a_y); end
    tick(); tick(); tick(); tick();
    checks++; if (a_x !== 10'd314) begin failures++; $display("FAIL move_second_x got %0d want 314", a_x); end
  endtask

  task automatic test_speedup();
    start_serve_play(1'b0);
    hr = 1'b1;
    hit_zone = 2'd0;
    tick();
    checks++; if (b_period !== 19'd27500) begin failures++; $display("FAIL speed_hit1 got %0d want 27500", b_period); end
    checks++; if (a_period !== 19'd2) begin failures++; $display("FAIL speed_fast_hit1 got %0d want 2", a_period); end
    tick();
    checks++; if (b_period !== 19'd20000) begin failures++; $display("FAIL speed_hit2 got %0d want 20000", b_period); end
    tick();
    hr = 1'b0;
    checks++; if (b_period !== 19'd20000) begin failures++; $display("FAIL speed_floor got %0d want 20000", b_period); end
    checks++; if (a_period !== 19'd1) begin failures++; $display("FAIL speed_fast_floor got %0d want 1", a_period); end
  endtask

  task automatic test_clamp_and_double_hits();
    start_serve_play(1'b0);
    hr = 1'b1; hb = 1'b1; hit_zone = 2'd3;
    tick();
    hr = 1'b0; hb = 1'b0;
    for (int i = 0; i < 1000 && a_y !== 10'd1; i++) tick();
    checks++; if (a_y !== 10'd1) begin failures++; $display("FAIL clamp_reach_y got %0d want 1", a_y); end
    checks++; if (a_x !== 10'd235) begin failures++; $display("FAIL clamp_reach_x got %0d want 235", a_x); end
    for (int i = 0; i < 10 && a_y === 10'd1; i++) tick();
    checks++; if (a_y !== 10'd0) begin failures++; $display("FAIL clamp_y got %0d want 0", a_y); end
    checks++; if (a_x !== 10'd234) begin failures++; $display("FAIL clamp_x got %0d want 234", a_x); end
    hl = 1'b1; hr = 1'b1; ht = 1'b1; hb = 1'b1;
    tick();
    hl = 1'b0; hr = 1'b0; ht = 1'b0; hb = 1'b0;
    checks++; if (a_period !== 19'd2) begin failures++; $display("FAIL both_paddles_period got %0d want 2", a_period); end
    for (int i = 0; i < 10 && a_x === 10'd234; i++) tick();
    checks++; if (a_x !== 10'd235) begin failures++; $display("FAIL both_paddles_x got %0d want 235", a_x); end
    checks++; if (a_y !== 10'd3) begin failures++; $display("FAIL both_walls_y got %0d want 3", a_y); end
  endtask

  task automatic test_flat_shot();
    start_serve_play(1'b0);
    hl = 1'b1; hit_zone = 2'd0;
    tick();
    hl = 1'b0;
    for (int i = 0; i < 10 && a_x === 10'd312; i++) tick();
    checks++; if (a_x !== 10'd313) begin failures++; $display("FAIL flat_x got %0d want 313", a_x); end
    checks++; if (a_y !== 10'd232) begin failures++; $display("FAIL flat_y got %0d want 232", a_y); end
  endtask

  task automatic test_score();
    int pulses;
    start_serve_play(1'b1);
    for (int i = 0; i < 2000 && a_x !== 10'd0; i++) tick();
    checks++; if (a_x !== 10'd0) begin failures++; $display("FAIL score_reach_x got %0d want 0", a_x); end
    checks++; if (a_st !== 2'b00) begin failures++; $display("FAIL score_pre_status got %b want 00", a_st); end
    for (int i = 0; i < 10 && a_st === 2'b00; i++) tick();
    checks++; if (a_st !== 2'b10) begin failures++; $display("FAIL score_status got %b want 10", a_st); end
    checks++; if (a_pulse !== 1'b1) begin failures++; $display("FAIL score_pulse_high got %b want 1", a_pulse); end
    checks++; if (a_y !== 10'd0) begin failures++; $display("FAIL score_y got %0d want 0", a_y); end
    pulses = 0;
    hr = 1'b1;
    tick();
    hr = 1'b0;
    checks++; if (a_pulse !== 1'b0) begin failures++; $display("FAIL score_pulse_low got %b want 0", a_pulse); end
    for (int i = 0; i < 99; i++) begin
      tick();
      if (a_pulse === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL score_pulse_repeat got %0d want 0", pulses); end
    checks++; if (a_x !== 10'd0 || a_y !== 10'd0) begin failures++; $display("FAIL score_hold_xy got %0d,%0d want 0,0", a_x, a_y); end
    checks++; if (a_st !== 2'b10) begin failures++; $display("FAIL score_hold_status got %b want 10", a_st); end
    checks++; if (a_period !== 19'd3) begin failures++; $display("FAIL score_frozen_hit got %0d want 3", a_period); end
    state = 2'b11;
    tick();
    checks++; if (a_x !== 10'd312 || a_y !== 10'd232) begin failures++; $display("FAIL done_origin got %0d,%0d want 312,232", a_x, a_y); end
    checks++; if (a_st !== 2'b00) begin failures++; $display("FAIL done_status got %b want 00", a_st); end
  endtask

  task automatic test_rst_mid_play();
    start_serve_play(1'b0);
    hit_zone = 2'd0;
    hr = 1'b1;
    tick();
    hr = 1'b0;
    hl = 1'b1;
    tick();
    hl = 1'b0;
    for (int i = 0; i < 1000 && a_x !== 10'd400; i++) tick();
    checks++; if (a_x !== 10'd400) begin failures++; $display("FAIL rst_reach_x got %0d want 400", a_x); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (a_x !== 10'd312 || a_y !== 10'd232) begin failures++; $display("FAIL rst_mid_xy got %0d,%0d want 312,232", a_x, a_y); end
    checks++; if (a_period !== 19'd3) begin failures++; $display("FAIL rst_mid_period got %0d want 3", a_period); end
    checks++; if (b_period !== 19'd40000) begin failures++; $display("FAIL rst_mid_period_slow got %0d want 40000", b_period); end
    checks++; if (a_pulse !== 1'b0 || a_st !== 2'b00) begin failures++; $display("FAIL rst_mid_status got %b/%b want 0/00", a_pulse, a_st); end
    state = 2'b00;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    state = 2'b00;
    serve_dir = 1'b0;
    hl = 1'b0; hr = 1'b0; ht = 1'b0; hb = 1'b0;
    hit_zone = 2'd0;
    test_reset();
    test_serve_move();
    test_speedup();
    test_clamp_and_double_hits();
    test_flat_shot();
    test_score();
    test_rst_mid_play();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
